// File: rtl/int_sync_gateway.sv
// int_sync_gateway: level-interrupt gateway with one IDLE/PENDING/INFLIGHT FSM per
// source, fixed-priority claim (lowest index wins) and ID-addressed completion.
//
// Optional build macro: INT_SYNC_GATEWAY_INPUT_SYNC_EN
//   - defined:   io_int_in passes through a 2-flop synchronizer per bit, so an
//                input edge reaches io_pending after 3 cycles.
//   - undefined: io_int_in is sampled directly, so io_pending follows after 1 cycle.
//
// Handshake semantics:
//   claim    : io_claim_valid is presented from registers only. A claim is accepted
//              on a rising edge where io_claim_valid && io_claim_ready. On that edge
//              the source named by io_claim_id moves PENDING -> INFLIGHT. When
//              io_claim_valid is low, io_claim_ready has no effect.
//   complete : io_complete_valid is a one-cycle command with no back-pressure. It
//              acts only if io_complete_id names a source that is INFLIGHT on that
//              edge. Otherwise it is dropped.
//
// FSM visibility: io_pending and io_inflight together are the full per-source
// state encoding. Both low means IDLE.
module int_sync_gateway #(
    parameter int NUM_INT = 2,
    parameter int IDW     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_INT-1:0] io_int_in,
    output logic               io_claim_valid,
    output logic [IDW-1:0]     io_claim_id,
    input  logic               io_claim_ready,
    input  logic               io_complete_valid,
    input  logic [IDW-1:0]     io_complete_id,
    output logic [NUM_INT-1:0] io_pending,
    output logic [NUM_INT-1:0] io_inflight
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } state_t;

    state_t             state_q [NUM_INT];
    logic [NUM_INT-1:0] int_s;
    logic [IDW-1:0]     grant_id;
    logic               claim_fire;

`ifdef INT_SYNC_GATEWAY_INPUT_SYNC_EN
    logic [NUM_INT-1:0] sync1_q;
    logic [NUM_INT-1:0] sync2_q;

    // Two-flop synchronizer on every interrupt line, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_int_in;
            sync2_q <= sync1_q;
        end
    end

    assign int_s = sync2_q;
`else
    assign int_s = io_int_in;
`endif

    // Decode the state registers into the per-source status vectors.
    always_comb begin
        io_pending  = '0;
        io_inflight = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            io_pending[i]  = (state_q[i] == ST_PENDING);
            io_inflight[i] = (state_q[i] == ST_INFLIGHT);
        end
    end

    // Fixed-priority arbiter. Scanning downward lets the lowest pending index win.
    always_comb begin
        grant_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (io_pending[i]) begin
                grant_id = IDW'(i + 1);
            end
        end
    end

    assign io_claim_valid = |io_pending;
    assign io_claim_id    = grant_id;
    assign claim_fire     = io_claim_valid && io_claim_ready;

    // Per-source FSMs: latch interrupts, hand the winner over on claim, retire on complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_INT; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_INT; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (int_s[i]) begin
                            state_q[i] <= ST_PENDING;
                        end
                    end
                    ST_PENDING: begin
                        // Only the single granted source moves on a claim.
                        if (claim_fire && (grant_id == IDW'(i + 1))) begin
                            state_q[i] <= ST_INFLIGHT;
                        end
                    end
                    ST_INFLIGHT: begin
                        // The input is ignored here. A still-high line re-pends
                        // after one IDLE cycle.
                        if (io_complete_valid && (io_complete_id == IDW'(i + 1))) begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_sync_gateway.sv
// tb_int_sync_gateway: directed vector table plus a random phase against a
// bit-vector reference model, for the default build of int_sync_gateway.
module tb_int_sync_gateway;

  localparam int NUM_INT = 2;
  localparam int IDW     = 2;
  localparam int EW      = 2 * NUM_INT + 1 + IDW;

  logic               clock;
  logic               reset;
  logic [NUM_INT-1:0] io_int_in;
  logic               io_claim_valid;
  logic [IDW-1:0]     io_claim_id;
  logic               io_claim_ready;
  logic               io_complete_valid;
  logic [IDW-1:0]     io_complete_id;
  logic [NUM_INT-1:0] io_pending;
  logic [NUM_INT-1:0] io_inflight;

  int total = 0;
  int bad   = 0;

  // expected {pending, inflight, claim_valid, claim_id}
  logic [EW-1:0] exp_q[$];
  string         name_q[$];

  typedef struct {
    logic       rst;
    logic [1:0] in;
    logic       rdy;
    logic       cv;
    logic [1:0] cid;
    logic [1:0] p;
    logic [1:0] f;
    logic       v;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];

  int_sync_gateway #(.NUM_INT(NUM_INT), .IDW(IDW)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_int_in         (io_int_in),
    .io_claim_valid    (io_claim_valid),
    .io_claim_id       (io_claim_id),
    .io_claim_ready    (io_claim_ready),
    .io_complete_valid (io_complete_valid),
    .io_complete_id    (io_complete_id),
    .io_pending        (io_pending),
    .io_inflight       (io_inflight)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic rst, input logic [1:0] in, input logic rdy,
                     input logic cv, input logic [1:0] cid,
                     input logic [1:0] p, input logic [1:0] f,
                     input logic v, input logic [1:0] id);
    vec_t t;
    t.rst = rst; t.in = in; t.rdy = rdy; t.cv = cv; t.cid = cid;
    t.p = p; t.f = f; t.v = v; t.id = id;
    vecs.push_back(t);
  endtask

  // Drive one cycle, queue its expected post-edge outputs, then compare them.
  task automatic step(input string nm, input logic rst, input logic [1:0] in,
                      input logic rdy, input logic cv, input logic [1:0] cid,
                      input logic [EW-1:0] expv);
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    string         n;
    @(negedge clock);
    reset             = rst;
    io_int_in         = in;
    io_claim_ready    = rdy;
    io_complete_valid = cv;
    io_complete_id    = cid;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
    e   = exp_q.pop_front();
    n   = name_q.pop_front();
    act = {io_pending, io_inflight, io_claim_valid, io_claim_id};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got pend=%b infl=%b cv=%b id=%0d, want pend=%b infl=%b cv=%b id=%0d",
               n, act[6:5], act[4:3], act[2], act[1:0], e[6:5], e[4:3], e[2], e[1:0]);
    end
  endtask

  // reference model state for the random phase
  logic [1:0] mp, mf;

  function automatic logic [1:0] model_id(input logic [1:0] p);
    if (p[0]) return 2'd1;
    if (p[1]) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    reset = 1'b1; io_int_in = '0; io_claim_ready = 0;
    io_complete_valid = 0; io_complete_id = '0;

    //   rst in     rdy cv cid    p      f      v id
    add(1, 2'b11, 1, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0); // reset ignores inputs
    add(1, 2'b11, 1, 1, 2'd2,  2'b00, 2'b00, 0, 2'd0);
    add(0, 2'b11, 0, 0, 2'd0,  2'b11, 2'b00, 1, 2'd1); // both pend, src0 wins
    add(0, 2'b00, 0, 0, 2'd0,  2'b11, 2'b00, 1, 2'd1); // latched after drop
    add(0, 2'b00, 1, 0, 2'd0,  2'b10, 2'b01, 1, 2'd2); // claim src0
    add(0, 2'b00, 0, 1, 2'd3,  2'b10, 2'b01, 1, 2'd2); // complete id>NUM_INT ignored
    add(0, 2'b00, 0, 1, 2'd0,  2'b10, 2'b01, 1, 2'd2); // complete id 0 ignored
    add(0, 2'b00, 0, 1, 2'd2,  2'b10, 2'b01, 1, 2'd2); // complete of pending src ignored
    add(0, 2'b00, 1, 0, 2'd0,  2'b00, 2'b11, 0, 2'd0); // claim src1
    add(0, 2'b00, 1, 0, 2'd0,  2'b00, 2'b11, 0, 2'd0); // ready w/o valid: no effect
    add(0, 2'b11, 0, 0, 2'd0,  2'b00, 2'b11, 0, 2'd0); // inputs ignored while inflight
    add(0, 2'b00, 0, 1, 2'd2,  2'b00, 2'b01, 0, 2'd0); // complete src1
    add(0, 2'b00, 0, 1, 2'd2,  2'b00, 2'b01, 0, 2'd0); // complete of idle src ignored
    add(0, 2'b00, 0, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0); // complete src0
    add(0, 2'b10, 0, 0, 2'd0,  2'b10, 2'b00, 1, 2'd2);
    add(0, 2'b00, 1, 0, 2'd0,  2'b00, 2'b10, 0, 2'd0); // src1 inflight
    add(0, 2'b01, 0, 0, 2'd0,  2'b01, 2'b10, 1, 2'd1);
    add(0, 2'b00, 1, 1, 2'd2,  2'b00, 2'b01, 0, 2'd0); // claim 1 + complete 2 same edge
    add(0, 2'b01, 0, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0); // complete while line high
    add(0, 2'b01, 0, 0, 2'd0,  2'b01, 2'b00, 1, 2'd1); // re-pend after one idle cycle
    add(0, 2'b01, 1, 0, 2'd0,  2'b00, 2'b01, 0, 2'd0);
    add(0, 2'b01, 0, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0);
    add(0, 2'b00, 0, 0, 2'd0,  2'b00, 2'b00, 0, 2'd0); // line dropped in idle cycle
    add(0, 2'b01, 0, 0, 2'd0,  2'b01, 2'b00, 1, 2'd1);
    add(0, 2'b00, 1, 1, 2'd1,  2'b00, 2'b01, 0, 2'd0); // claim+complete same id
    add(0, 2'b00, 0, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0);
    add(0, 2'b11, 0, 0, 2'd0,  2'b11, 2'b00, 1, 2'd1); // reset mid-operation
    add(0, 2'b11, 1, 0, 2'd0,  2'b10, 2'b01, 1, 2'd2);
    add(1, 2'b11, 1, 1, 2'd1,  2'b00, 2'b00, 0, 2'd0);
    add(1, 2'b11, 1, 0, 2'd0,  2'b00, 2'b00, 0, 2'd0);
    add(0, 2'b11, 0, 0, 2'd0,  2'b11, 2'b00, 1, 2'd1); // re-pend 1 cycle after reset
    add(1, 2'b00, 0, 0, 2'd0,  2'b00, 2'b00, 0, 2'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      step($sformatf("vec%0d", k), vecs[k].rst, vecs[k].in, vecs[k].rdy,
           vecs[k].cv, vecs[k].cid, {vecs[k].p, vecs[k].f, vecs[k].v, vecs[k].id});
    end

    // quiet period after reset: everything stays at zero
    for (int k = 0; k < 10; k++) begin
      step($sformatf("quiet%0d", k), 0, 2'b00, 1'($urandom_range(0, 1)), 0, 2'd0, '0);
    end

    // random phase against a bit-vector reference model
    mp = '0; mf = '0;
    for (int k = 0; k < 400; k++) begin
      logic       r_rst, r_rdy, r_cv, fire;
      logic [1:0] r_in, r_cid, win, np, nf;
      r_rst = ($urandom_range(0, 39) == 0);
      r_in  = 2'($urandom_range(0, 3));
      r_rdy = 1'($urandom_range(0, 1));
      r_cv  = 1'($urandom_range(0, 1));
      r_cid = 2'($urandom_range(0, 3));
      fire  = (mp != 2'b00) && r_rdy;
      win   = model_id(mp);
      np = mp; nf = mf;
      for (int i = 0; i < NUM_INT; i++) begin
        if (mf[i]) begin
          if (r_cv && r_cid == 2'(i + 1)) nf[i] = 1'b0;
        end else if (mp[i]) begin
          if (fire && win == 2'(i + 1)) begin
            np[i] = 1'b0;
            nf[i] = 1'b1;
          end
        end else if (r_in[i]) begin
          np[i] = 1'b1;
        end
      end
      if (r_rst) begin
        np = '0; nf = '0;
      end
      mp = np; mf = nf;
      step($sformatf("rand%0d", k), r_rst, r_in, r_rdy, r_cv, r_cid,
           {mp, mf, (mp != 2'b00), model_id(mp)});
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d leftover expected entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
